// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: drives F_PC and queues {PC, Instr} into a prefetch buffer for decode.
// Optional halt detection is enabled by defining HALT_DETECT_EN.
module instr_fetch_ctrl #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter int unsigned            PC_BITS     = 16,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned            BUF_DEPTH   = 4,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  output logic [ADDR_WIDTH-1:0]         F_PC,
  input  logic [INSTR_WIDTH-1:0]        Instr,
  input  logic                          redirect,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          D_valid,
  input  logic                          D_ready,
  output logic [INSTR_WIDTH-1:0]        D_instr,
  output logic [ADDR_WIDTH-1:0]         D_pc,
  output logic [$clog2(BUF_DEPTH):0]    count,
  output logic                          halted
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PcMask = ADDR_WIDTH'((64'd1 << PC_BITS) - 64'd1);
  localparam logic [PtrW:0] CountOne = (PtrW+1)'(1);
  localparam logic [PtrW:0] CountMax = (PtrW+1)'(BUF_DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  state_e                 r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]  r_pc, w_pc_next;
  logic [PtrW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]          r_count;
  logic [INSTR_WIDTH-1:0] r_buf_instr [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_buf_pc [BUF_DEPTH];
  logic                   w_pop, w_push, w_halt_hit;
  logic                   w_halt_en;

`ifdef HALT_DETECT_EN
  assign w_halt_en = 1'b1;
  assign halted    = (r_state == StHalted);
`else
  assign w_halt_en = 1'b0;
  assign halted    = 1'b0;
`endif

  assign w_pop      = (r_count != '0) & D_ready;
  assign w_push     = (r_state == StFetch) & ~redirect & ((r_count < CountMax) | w_pop);
  assign w_halt_hit = w_halt_en & w_push & (Instr == HALT_WORD);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (redirect) begin
      w_state_next = run ? StFetch : StIdle;
      w_pc_next    = redirect_pc & PcMask;
    end else begin
      unique case (r_state)
        StIdle:  if (run) w_state_next = StFetch;
        StFetch: begin
          if (w_halt_hit)  w_state_next = StHalted;
          else if (!run)   w_state_next = StIdle;
        end
        default: w_state_next = r_state;
      endcase
      // Halt word is enqueued but the PC stays on it.
      if (w_push && !w_halt_hit) w_pc_next = (r_pc + ADDR_WIDTH'(1)) & PcMask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
        if (w_push && !w_pop)      r_count <= r_count + CountOne;
        else if (w_pop && !w_push) r_count <= r_count - CountOne;
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= Instr;
      r_buf_pc[r_wr_ptr]    <= r_pc;
    end
  end

  assign F_PC    = r_pc;
  assign count   = r_count;
  assign D_valid = (r_count != '0);
  assign D_instr = D_valid ? r_buf_instr[r_rd_ptr] : '0;
  assign D_pc    = D_valid ? r_buf_pc[r_rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl; a second instance checks PC wrap from RESET_PC=0xFFFF.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, redirect, D_ready, halt_mem;
  logic [31:0] redirect_pc;
  logic [31:0] f_pc, instr, d_instr, d_pc;
  logic        d_valid, halted;
  logic [2:0]  count;
  logic [31:0] w_f_pc, w_d_instr, w_d_pc;
  logic        w_d_valid, w_halted;
  logic [2:0]  w_count;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Memory model: memory[n] = n, optionally with HALT_WORD at address 3.
  assign instr = (halt_mem && f_pc == 32'd3) ? 32'hFFFF_FFFF : f_pc;

  instr_fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .run(run), .F_PC(f_pc), .Instr(instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .D_valid(d_valid), .D_ready(D_ready),
    .D_instr(d_instr), .D_pc(d_pc), .count(count), .halted(halted)
  );

  instr_fetch_ctrl #(.RESET_PC(32'h0000_FFFF)) u_wrap (
    .clk(clk), .reset(reset), .run(run), .F_PC(w_f_pc), .Instr(w_f_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .D_valid(w_d_valid), .D_ready(D_ready),
    .D_instr(w_d_instr), .D_pc(w_d_pc), .count(w_count), .halted(w_halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; run = 1'b0; redirect = 1'b0; D_ready = 1'b0; halt_mem = 1'b0;
    redirect_pc = '0;
    #3;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (f_pc !== 32'd0) begin n_fail++; $display("FAIL reset_fpc: got %h want %h", f_pc, 32'd0); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid: got %b want 0", d_valid); end
    n_cmp++; if (d_instr !== 32'd0 || d_pc !== 32'd0) begin n_fail++;
      $display("FAIL reset_head: got instr %h pc %h want 0 0", d_instr, d_pc); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (w_f_pc !== 32'h0000_FFFF) begin n_fail++;
      $display("FAIL reset_wrap_fpc: got %h want 0000ffff", w_f_pc); end
  endtask

  task automatic test_stream();
    apply_reset();
    D_ready = 1'b1; run = 1'b1;
    step();
    n_cmp++; if (d_valid !== 1'b0 || f_pc !== 32'd0) begin n_fail++;
      $display("FAIL stream_c1: got valid %b fpc %h want 0 0", d_valid, f_pc); end
    step();
    n_cmp++; if (d_valid !== 1'b1 || d_pc !== 32'd0 || d_instr !== 32'd0 || count !== 3'd1) begin
      n_fail++; $display("FAIL stream_c2: got valid %b pc %h instr %h cnt %0d want 1 0 0 1",
                         d_valid, d_pc, d_instr, count); end
    n_cmp++; if (f_pc !== 32'd1) begin n_fail++; $display("FAIL stream_fpc: got %h want 1", f_pc); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (d_pc !== k || d_instr !== k || count !== 3'd1) begin n_fail++;
        $display("FAIL stream_seq%0d: got pc %h instr %h cnt %0d want %h %h 1",
                 k, d_pc, d_instr, count, k, k); end
    end
  endtask

  task automatic test_backpressure_redirect();
    apply_reset();
    D_ready = 1'b0; run = 1'b1;
    repeat (5) step();
    n_cmp++; if (count !== 3'd4 || f_pc !== 32'd4) begin n_fail++;
      $display("FAIL bp_full: got cnt %0d fpc %h want 4 4", count, f_pc); end
    step();
    n_cmp++; if (count !== 3'd4 || f_pc !== 32'd4 || d_pc !== 32'd0 || d_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got cnt %0d fpc %h pc %h valid %b want 4 4 0 1",
                         count, f_pc, d_pc, d_valid); end
    D_ready = 1'b1;
    step();
    n_cmp++; if (count !== 3'd4 || f_pc !== 32'd5 || d_pc !== 32'd1) begin n_fail++;
      $display("FAIL bp_poppush: got cnt %0d fpc %h pc %h want 4 5 1", count, f_pc, d_pc); end
    run = 1'b0;
    step();
    step();
    n_cmp++; if (count !== 3'd3 || d_pc !== 32'd3 || f_pc !== 32'd6) begin n_fail++;
      $display("FAIL idle_drain: got cnt %0d pc %h fpc %h want 3 3 6", count, d_pc, f_pc); end
    D_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h20; run = 1'b1;
    step();
    redirect = 1'b0;
    n_cmp++; if (count !== 3'd0 || d_valid !== 1'b0 || f_pc !== 32'h20) begin n_fail++;
      $display("FAIL redir_flush: got cnt %0d valid %b fpc %h want 0 0 20", count, d_valid, f_pc); end
    step();
    n_cmp++; if (d_pc !== 32'h20 || d_instr !== 32'h20 || count !== 3'd1 || f_pc !== 32'h21) begin
      n_fail++; $display("FAIL redir_resume: got pc %h instr %h cnt %0d fpc %h want 20 20 1 21",
                         d_pc, d_instr, count, f_pc); end
    run = 1'b0; redirect = 1'b1; redirect_pc = 32'h0001_0030;
    step();
    redirect = 1'b0;
    n_cmp++; if (f_pc !== 32'h30 || count !== 3'd0) begin n_fail++;
      $display("FAIL redir_mask: got fpc %h cnt %0d want 30 0", f_pc, count); end
    step();
    n_cmp++; if (f_pc !== 32'h30 || count !== 3'd0) begin n_fail++;
      $display("FAIL redir_idle: got fpc %h cnt %0d want 30 0", f_pc, count); end
  endtask

  task automatic test_wrap();
    apply_reset();
    D_ready = 1'b1; run = 1'b1;
    step();
    step();
    n_cmp++; if (w_d_pc !== 32'h0000_FFFF || w_d_instr !== 32'h0000_FFFF || w_f_pc !== 32'd0) begin
      n_fail++; $display("FAIL wrap_first: got pc %h instr %h fpc %h want ffff ffff 0",
                         w_d_pc, w_d_instr, w_f_pc); end
    step();
    n_cmp++; if (w_d_pc !== 32'd0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", w_d_pc); end
    step();
    n_cmp++; if (w_d_pc !== 32'd1) begin n_fail++; $display("FAIL wrap_one: got %h want 1", w_d_pc); end
  endtask

  task automatic test_halt();
    apply_reset();
    halt_mem = 1'b1; D_ready = 1'b1; run = 1'b1;
    step();
    for (int k = 0; k <= 3; k++) begin
      step();
      n_cmp++; if (d_pc !== k) begin n_fail++; $display("FAIL halt_seq%0d: got %h want %h", k, d_pc, k); end
    end
    n_cmp++; if (d_instr !== 32'hFFFF_FFFF) begin n_fail++;
      $display("FAIL halt_word: got %h want ffffffff", d_instr); end
`ifdef HALT_DETECT_EN
    n_cmp++; if (halted !== 1'b1 || f_pc !== 32'd3) begin n_fail++;
      $display("FAIL halt_enter: got halted %b fpc %h want 1 3", halted, f_pc); end
    step();
    n_cmp++; if (halted !== 1'b1 || f_pc !== 32'd3 || d_valid !== 1'b0) begin n_fail++;
      $display("FAIL halt_stay: got halted %b fpc %h valid %b want 1 3 0", halted, f_pc, d_valid); end
`else
    n_cmp++; if (halted !== 1'b0 || f_pc !== 32'd4) begin n_fail++;
      $display("FAIL nohalt_pass: got halted %b fpc %h want 0 4", halted, f_pc); end
    step();
    n_cmp++; if (halted !== 1'b0 || d_pc !== 32'd4 || d_valid !== 1'b1) begin n_fail++;
      $display("FAIL nohalt_next: got halted %b pc %h valid %b want 0 4 1", halted, d_pc, d_valid); end
`endif
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    n_cmp++; if (halted !== 1'b0 || f_pc !== 32'h10 || count !== 3'd0) begin n_fail++;
      $display("FAIL halt_redir: got halted %b fpc %h cnt %0d want 0 10 0", halted, f_pc, count); end
    step();
    n_cmp++; if (d_pc !== 32'h10 || f_pc !== 32'h11) begin n_fail++;
      $display("FAIL halt_resume: got pc %h fpc %h want 10 11", d_pc, f_pc); end
    halt_mem = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    D_ready = 1'b0; run = 1'b1;
    repeat (3) step();
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL areset_pre: got %0d want 2", count); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (d_valid !== 1'b0 || count !== 3'd0 || f_pc !== 32'd0 || d_instr !== 32'd0) begin
      n_fail++; $display("FAIL areset_now: got valid %b cnt %0d fpc %h instr %h want 0 0 0 0",
                         d_valid, count, f_pc, d_instr); end
    step();
    reset = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
